// File: rtl/mngr_pkg.sv
// Shared constants for the processor/manager message port.
// CSR numbers and default sizing live here so both ends agree.
package mngr_pkg;

  localparam int MNGR_W     = 32;
  localparam int MNGR_DEPTH = 2;

  localparam logic [11:0] CSR_MNGR2PROC = 12'hFC0;
  localparam logic [11:0] CSR_PROC2MNGR = 12'h7C0;

endpackage

// File: rtl/mngr_fifo.sv
// Small val/rdy FIFO with combinational head and occupancy count.
// Full/empty come from the counter; no enqueue-to-dequeue bypass.
module mngr_fifo
  import mngr_pkg::*;
#(
  parameter  int DEPTH = MNGR_DEPTH,
  parameter  int W     = MNGR_W,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enq_val_i,
  output logic          enq_rdy_o,
  input  logic [W-1:0]  enq_msg_i,
  output logic          deq_val_o,
  input  logic          deq_rdy_i,
  output logic [W-1:0]  deq_msg_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full, empty;
  logic          enq_fire, deq_fire;

  // Reset forces the empty view so outputs are clean while rst is held.
  assign full  = !rst && (cnt_q == CW'(DEPTH));
  assign empty = rst || (cnt_q == '0);

  assign enq_rdy_o = !full;
  assign deq_val_o = !empty;
  assign enq_fire  = enq_val_i && !full;
  assign deq_fire  = deq_rdy_i && !empty;

  assign deq_msg_o = empty ? '0 : mem_q[rd_ptr_q];
  assign count_o   = rst ? '0 : cnt_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (enq_fire) wr_ptr_d = wr_ptr_q + AW'(1);
    if (deq_fire) rd_ptr_d = rd_ptr_q + AW'(1);
    if (enq_fire && !deq_fire) cnt_d = cnt_q + CW'(1);
    if (!enq_fire && deq_fire) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_fire) mem_q[wr_ptr_q] <= enq_msg_i;
  end

endmodule

// File: rtl/proc_mngr_port.sv
// Manager <-> processor message port behind the mngr2proc and
// proc2mngr CSRs; one FIFO per direction, pipeline stalls on empty/full.
module proc_mngr_port
  import mngr_pkg::*;
#(
  parameter  int DEPTH = MNGR_DEPTH,
  parameter  int W     = MNGR_W,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mngr2proc_val,
  output logic          mngr2proc_rdy,
  input  logic [W-1:0]  mngr2proc_msg,
  output logic          proc2mngr_val,
  input  logic          proc2mngr_rdy,
  output logic [W-1:0]  proc2mngr_msg,
  input  logic          csr_rd_en,
  output logic [W-1:0]  csr_rd_data,
  output logic          csr_rd_stall,
  input  logic          csr_wr_en,
  input  logic [W-1:0]  csr_wr_data,
  output logic          csr_wr_stall,
  output logic [CW-1:0] rx_count,
  output logic [CW-1:0] tx_count
);

  logic rx_val;
  logic tx_rdy;

  mngr_fifo #(.DEPTH(DEPTH), .W(W)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .enq_val_i (mngr2proc_val),
    .enq_rdy_o (mngr2proc_rdy),
    .enq_msg_i (mngr2proc_msg),
    .deq_val_o (rx_val),
    .deq_rdy_i (csr_rd_en),
    .deq_msg_o (csr_rd_data),
    .count_o   (rx_count)
  );

  mngr_fifo #(.DEPTH(DEPTH), .W(W)) u_tx (
    .clk       (clk),
    .rst       (rst),
    .enq_val_i (csr_wr_en),
    .enq_rdy_o (tx_rdy),
    .enq_msg_i (csr_wr_data),
    .deq_val_o (proc2mngr_val),
    .deq_rdy_i (proc2mngr_rdy),
    .deq_msg_o (proc2mngr_msg),
    .count_o   (tx_count)
  );

  assign csr_rd_stall = csr_rd_en && !rx_val;
  assign csr_wr_stall = csr_wr_en && !tx_rdy;

endmodule

// File: tb/tb_proc_mngr_port.sv
// Scoreboard bench for proc_mngr_port: stimulus pushes expected
// messages, a negedge monitor pops and compares on each handshake.
module tb_proc_mngr_port;

  localparam int DEPTH = 2;
  localparam int W     = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          mngr2proc_val;
  logic          mngr2proc_rdy;
  logic [W-1:0]  mngr2proc_msg;
  logic          proc2mngr_val;
  logic          proc2mngr_rdy;
  logic [W-1:0]  proc2mngr_msg;
  logic          csr_rd_en;
  logic [W-1:0]  csr_rd_data;
  logic          csr_rd_stall;
  logic          csr_wr_en;
  logic [W-1:0]  csr_wr_data;
  logic          csr_wr_stall;
  logic [CW-1:0] rx_count;
  logic [CW-1:0] tx_count;

  proc_mngr_port #(.DEPTH(DEPTH), .W(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .mngr2proc_val (mngr2proc_val),
    .mngr2proc_rdy (mngr2proc_rdy),
    .mngr2proc_msg (mngr2proc_msg),
    .proc2mngr_val (proc2mngr_val),
    .proc2mngr_rdy (proc2mngr_rdy),
    .proc2mngr_msg (proc2mngr_msg),
    .csr_rd_en     (csr_rd_en),
    .csr_rd_data   (csr_rd_data),
    .csr_rd_stall  (csr_rd_stall),
    .csr_wr_en     (csr_wr_en),
    .csr_wr_data   (csr_wr_data),
    .csr_wr_stall  (csr_wr_stall),
    .rx_count      (rx_count),
    .tx_count      (tx_count)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned rx_pops = 0;
  int unsigned tx_pops = 0;

  logic [W-1:0] rx_q [$];
  logic [W-1:0] tx_q [$];

  logic         prev_block = 1'b0;
  logic [W-1:0] prev_msg   = '0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: handshakes are judged mid-cycle, before the edge that fires them.
  always @(negedge clk) begin
    if (rst) begin
      prev_block = 1'b0;
    end else begin
      if (csr_rd_en && !csr_rd_stall) begin
        if (rx_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rx_unexpected: got 0x%0h expected none", csr_rd_data);
        end else begin
          chk("rx_data", csr_rd_data, rx_q.pop_front());
        end
        rx_pops++;
      end
      if (proc2mngr_val && proc2mngr_rdy) begin
        if (tx_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL tx_unexpected: got 0x%0h expected none", proc2mngr_msg);
        end else begin
          chk("tx_data", proc2mngr_msg, tx_q.pop_front());
        end
        tx_pops++;
      end
      if (prev_block && proc2mngr_val)
        chk("tx_stable", proc2mngr_msg, prev_msg);
      chk("rx_count_le_depth", 32'(rx_count <= CW'(DEPTH)), 32'd1);
      chk("tx_count_le_depth", 32'(tx_count <= CW'(DEPTH)), 32'd1);
      prev_block = proc2mngr_val && !proc2mngr_rdy;
      prev_msg   = proc2mngr_msg;
    end
  end

  task automatic mngr_send(input logic [W-1:0] v);
    int t;
    logic ok;
    t = 0;
    mngr2proc_val = 1'b1;
    mngr2proc_msg = v;
    rx_q.push_back(v);
    do begin
      @(negedge clk);
      ok = mngr2proc_rdy;
      step();
      t++;
    end while (!ok && t < 60);
    if (!ok) chk("mngr_send_timeout", 32'd0, 32'd1);
    mngr2proc_val = 1'b0;
  endtask

  task automatic csr_write(input logic [W-1:0] v);
    int t;
    logic ok;
    t = 0;
    csr_wr_en   = 1'b1;
    csr_wr_data = v;
    tx_q.push_back(v);
    do begin
      @(negedge clk);
      ok = !csr_wr_stall;
      step();
      t++;
    end while (!ok && t < 60);
    if (!ok) chk("csr_write_timeout", 32'd0, 32'd1);
    csr_wr_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base_rx;
    int base_tx;
    int t;
    rst           = 1'b1;
    mngr2proc_val = 1'b0;
    mngr2proc_msg = '0;
    proc2mngr_rdy = 1'b0;
    csr_rd_en     = 1'b1;
    csr_wr_en     = 1'b1;
    csr_wr_data   = 32'hDEAD;

    // Reset values while rst is held
    step();
    @(negedge clk);
    chk("rst_mngr2proc_rdy", 32'(mngr2proc_rdy), 32'd1);
    chk("rst_proc2mngr_val", 32'(proc2mngr_val), 32'd0);
    chk("rst_rd_stall", 32'(csr_rd_stall), 32'd1);
    chk("rst_wr_stall", 32'(csr_wr_stall), 32'd0);
    chk("rst_rx_count", 32'(rx_count), 32'd0);
    chk("rst_tx_count", 32'(tx_count), 32'd0);
    chk("rst_rd_data", csr_rd_data, 32'd0);
    step();
    csr_rd_en = 1'b0;
    csr_wr_en = 1'b0;
    rst       = 1'b0;
    step();

    // Single receive then read
    mngr2proc_val = 1'b1;
    mngr2proc_msg = 32'd33;
    rx_q.push_back(32'd33);
    @(negedge clk);
    chk("t35_rx_count0", 32'(rx_count), 32'd0);
    chk("t35_rd_data_nobypass", csr_rd_data, 32'd0);
    step();
    mngr2proc_val = 1'b0;
    csr_rd_en     = 1'b1;
    @(negedge clk);
    chk("t35_rx_count1", 32'(rx_count), 32'd1);
    chk("t35_no_stall", 32'(csr_rd_stall), 32'd0);
    chk("t35_rd_data", csr_rd_data, 32'd33);
    step();
    csr_rd_en = 1'b0;
    @(negedge clk);
    chk("t35_rx_count_after", 32'(rx_count), 32'd0);
    step();

    // Read stalls on empty until the manager sends
    csr_rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t36_stall_empty", 32'(csr_rd_stall), 32'd1);
      step();
    end
    mngr2proc_val = 1'b1;
    mngr2proc_msg = 32'h4B;
    rx_q.push_back(32'h4B);
    @(negedge clk);
    chk("t36_stall_enq_cycle", 32'(csr_rd_stall), 32'd1);
    step();
    mngr2proc_val = 1'b0;
    @(negedge clk);
    chk("t36_stall_released", 32'(csr_rd_stall), 32'd0);
    chk("t36_rd_data", csr_rd_data, 32'h4B);
    step();
    csr_rd_en = 1'b0;
    step();

    // Transmit backpressure: 3 stalls until the manager drains
    proc2mngr_rdy = 1'b0;
    csr_wr_en     = 1'b1;
    csr_wr_data   = 32'd1;
    tx_q.push_back(32'd1);
    @(negedge clk);
    chk("t37_wr1_stall", 32'(csr_wr_stall), 32'd0);
    step();
    csr_wr_data = 32'd2;
    tx_q.push_back(32'd2);
    @(negedge clk);
    chk("t37_wr2_stall", 32'(csr_wr_stall), 32'd0);
    step();
    csr_wr_data = 32'd3;
    @(negedge clk);
    chk("t37_wr3_stall", 32'(csr_wr_stall), 32'd1);
    chk("t37_tx_count_full", 32'(tx_count), 32'd2);
    chk("t37_head_blocked", proc2mngr_msg, 32'd1);
    step();
    @(negedge clk);
    chk("t37_wr3_still_stall", 32'(csr_wr_stall), 32'd1);
    step();
    proc2mngr_rdy = 1'b1;
    @(negedge clk);
    chk("t37_no_passthrough", 32'(csr_wr_stall), 32'd1);
    step();
    tx_q.push_back(32'd3);
    @(negedge clk);
    chk("t37_wr3_accepted", 32'(csr_wr_stall), 32'd0);
    chk("t37_tx_count_mid", 32'(tx_count), 32'd1);
    step();
    csr_wr_en = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("t37_tx_drained", 32'(tx_count), 32'd0);
    chk("t37_tx_pops", tx_pops, 32'd3);
    step();

    // Streaming with random gaps in both directions
    base_rx = rx_pops;
    base_tx = tx_pops;
    fork
      begin
        for (int i = 0; i < 7; i++) begin
          repeat ($urandom_range(0, 2)) step();
          mngr_send(32'h10 + 32'(i));
        end
      end
      begin
        for (int i = 0; i < 7; i++) begin
          repeat ($urandom_range(0, 2)) step();
          csr_write(32'h10 + 32'(i));
        end
      end
      begin
        for (int c = 0; c < 400 && rx_pops < base_rx + 7; c++) begin
          csr_rd_en = 1'($urandom_range(0, 1));
          step();
        end
        csr_rd_en = 1'b0;
      end
      begin
        for (int c = 0; c < 400 && tx_pops < base_tx + 7; c++) begin
          proc2mngr_rdy = 1'($urandom_range(0, 1));
          step();
        end
        proc2mngr_rdy = 1'b0;
      end
    join
    chk("t38_rx_delivered", rx_pops - base_rx, 32'd7);
    chk("t38_tx_delivered", tx_pops - base_tx, 32'd7);
    step();

    // Fill both FIFOs, then reset mid-operation
    proc2mngr_rdy = 1'b0;
    mngr2proc_val = 1'b1;
    mngr2proc_msg = 32'h55;
    csr_wr_en     = 1'b1;
    csr_wr_data   = 32'h66;
    step();
    mngr2proc_msg = 32'h56;
    csr_wr_data   = 32'h67;
    step();
    mngr2proc_val = 1'b0;
    csr_wr_en     = 1'b0;
    @(negedge clk);
    chk("t39_rx_full", 32'(rx_count), 32'd2);
    chk("t39_tx_full", 32'(tx_count), 32'd2);
    chk("t39_rdy_low_full", 32'(mngr2proc_rdy), 32'd0);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("t39_rst_rdy", 32'(mngr2proc_rdy), 32'd1);
    chk("t39_rst_val", 32'(proc2mngr_val), 32'd0);
    step();
    rst = 1'b0;
    rx_q.delete();
    tx_q.delete();
    @(negedge clk);
    chk("t39_rx_count", 32'(rx_count), 32'd0);
    chk("t39_tx_count", 32'(tx_count), 32'd0);
    chk("t39_val_after", 32'(proc2mngr_val), 32'd0);
    chk("t39_rdy_after", 32'(mngr2proc_rdy), 32'd1);
    step();
    mngr_send(32'h2A);
    csr_rd_en = 1'b1;
    @(negedge clk);
    chk("t39_first_read", csr_rd_data, 32'h2A);
    step();
    csr_rd_en = 1'b0;
    step();

    // rx full: read and manager offer in the same cycle
    mngr_send(32'h31);
    mngr_send(32'h32);
    mngr2proc_val = 1'b1;
    mngr2proc_msg = 32'h33;
    csr_rd_en     = 1'b1;
    rx_q.push_back(32'h33);
    @(negedge clk);
    chk("t40_rdy_low", 32'(mngr2proc_rdy), 32'd0);
    chk("t40_count_full", 32'(rx_count), 32'd2);
    step();
    csr_rd_en = 1'b0;
    @(negedge clk);
    chk("t40_rdy_next", 32'(mngr2proc_rdy), 32'd1);
    chk("t40_count_after_deq", 32'(rx_count), 32'd1);
    step();
    mngr2proc_val = 1'b0;
    @(negedge clk);
    chk("t40_count_after_enq", 32'(rx_count), 32'd2);
    step();
    csr_rd_en = 1'b1;
    step();
    step();
    csr_rd_en = 1'b0;
    @(negedge clk);
    chk("t40_rx_empty", 32'(rx_count), 32'd0);
    chk("t40_rd_data_zero", csr_rd_data, 32'd0);

    t = 0;
    while ((rx_q.size() != 0 || tx_q.size() != 0) && t < 20) begin
      step();
      t++;
    end
    chk("end_rx_q_empty", 32'(rx_q.size()), 32'd0);
    chk("end_tx_q_empty", 32'(tx_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/proc_mngr_port.md
PROC_MNGR_PORT -- requirements
Module: proc_mngr_port

Interface
REQ-001 Parameter DEPTH, default 2, SHALL set the entry count of each direction's FIFO (power of two, >=2).
REQ-002 Parameter W, default 32, SHALL set the message width.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 mngr2proc_val  input  1  manager offers a message.
REQ-006 mngr2proc_rdy  output  1  port accepts a manager message.
REQ-007 mngr2proc_msg  input  W  manager message.
REQ-008 proc2mngr_val  output  1  port offers a message to the manager.
REQ-009 proc2mngr_rdy  input  1  manager accepts.
REQ-010 proc2mngr_msg  output  W  message to the manager.
REQ-011 csr_rd_en  input  1  pipeline executes csrr mngr2proc this cycle.
REQ-012 csr_rd_data  output  W  head of the receive FIFO.
REQ-013 csr_rd_stall  output  1  read cannot complete; pipeline holds.
REQ-014 csr_wr_en  input  1  pipeline executes csrw proc2mngr this cycle.
REQ-015 csr_wr_data  input  W  value to send.
REQ-016 csr_wr_stall  output  1  write cannot complete; pipeline holds.
REQ-017 rx_count, tx_count  output  $clog2(DEPTH)+1 each  current FIFO occupancy.

Function
REQ-018 Receive FIFO: mngr2proc_rdy SHALL equal !rx_full; enqueue SHALL occur exactly on mngr2proc_val && mngr2proc_rdy.
REQ-019 Receive data SHALL become visible on csr_rd_data one cycle after enqueue (no bypass, even when empty).
REQ-020 csr_rd_data SHALL show the head entry combinationally; dequeue SHALL occur on csr_rd_en && !rx_empty.
REQ-021 csr_rd_stall SHALL equal csr_rd_en && rx_empty; a stalled read SHALL NOT change state.
REQ-022 Transmit FIFO: enqueue SHALL occur on csr_wr_en && !tx_full; csr_wr_stall SHALL equal csr_wr_en && tx_full.
REQ-023 A full FIFO SHALL stall/deassert rdy even if a dequeue occurs the same cycle (no pass-through).
REQ-024 proc2mngr_val SHALL equal !tx_empty; proc2mngr_msg SHALL be the head entry and SHALL remain stable while val && !rdy.
REQ-025 Transmit dequeue SHALL occur exactly on proc2mngr_val && proc2mngr_rdy.
REQ-026 Simultaneous enqueue and dequeue on a non-full, non-empty FIFO SHALL leave occupancy unchanged and preserve order.
REQ-027 Read/write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; full/empty SHALL derive from the occupancy counter.
REQ-028 Messages SHALL be delivered in FIFO order with no loss or duplication in either direction.
REQ-029 csr_rd_data SHALL be 0 when rx_empty.

Reset
REQ-030 While rst=1, pointers and counts SHALL clear: mngr2proc_rdy=1, proc2mngr_val=0, csr_rd_stall=csr_rd_en, csr_wr_stall=0, counts=0, csr_rd_data=0.
REQ-031 Reset mid-operation SHALL discard all buffered entries; no pre-reset message SHALL appear afterwards.
REQ-032 Storage arrays need no reset.

Structure
REQ-033 Package mngr_pkg SHALL hold CSR_MNGR2PROC=12'hFC0, CSR_PROC2MNGR=12'h7C0, and the default W/DEPTH constants.
REQ-034 One sub-module mngr_fifo (val/rdy enqueue, head + deq, count) SHALL be instantiated twice, once per direction.

Verification
REQ-035 Manager sends 33 (val=1 one cycle), csr_rd_en asserted next cycle -> csr_rd_data=33, no stall, rx_count 1->0.
REQ-036 csr_rd_en with rx empty for 3 cycles, then manager sends 0x4B -> stall high 4 cycles, read completes the cycle after enqueue with 0x4B.
REQ-037 proc2mngr_rdy=0, csr_wr_en with 1,2,3 -> 1,2 accepted, 3 stalls (tx_count=2); rdy=1 -> outputs 1,2,3 in order, msg stable while blocked.
REQ-038 Stream 7 values 0x10..0x16 each direction with random rdy/val gaps -> in-order delivery, pointer wrap exercised, counts never exceed DEPTH.
REQ-039 Fill both FIFOs, assert rst one cycle -> counts 0, proc2mngr_val=0, mngr2proc_rdy=1; subsequent send 0x2A is the first value read.
REQ-040 rx full with mngr2proc_val=1 and csr_rd_en same cycle -> dequeue only, mngr2proc_rdy=0 that cycle, enqueue the next cycle.
